ws2812b_capture_ctrl: RTL
=========================

// Module: ws2812b_capture_ctrl
// PURPOSE
//  Sequencing/config controller for the impostor WS2812B input path. Takes decoded bits from the pulse-width decoder.
//  Assembles bytes and generates byte_valid/idle strobes for the forwarding demux. Latches the first GRB triplet of each frame.
//  Exposes colour, status, control and frame count to the tinyQV peripheral bus, with a level interrupt.
// PARAMETERS
//  RESET_CYCLES  3200  din-low cycles that end a frame (50 us at 64 MHz); must be >= 2
//  CNT_W         12    idle-counter width; must satisfy 2**CNT_W > RESET_CYCLES
// PORTS
//  clk         in   1   clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  din_sync    in   1   synchronized DIN level
//  bit_valid   in   1   1-cycle strobe: decoded bit available
//  bit_value   in   1   decoded bit, qualified by bit_valid
//  addr        in   2   register address
//  wr_en       in   1   1-cycle register write strobe
//  wdata       in   32  write data
//  rd_en       in   1   1-cycle register read strobe
//  rdata       out  32  read data, valid when rd_ready=1
//  rd_ready    out  1   1-cycle pulse, the cycle after rd_en
//  byte_valid  out  1   1-cycle strobe to demux: 8th bit of a byte assembled
//  idle        out  1   1-cycle strobe to demux: frame-end (reset) detected
//  irq         out  1   level interrupt = NEW & IRQ_EN
// BEHAVIOUR
//  Reset: every output 0; shift reg, bit_cnt, byte_cnt, COLOR, STATUS, CTRL, FRAME_CNT and idle counter all cleared.
//  Bit assembly (EN=1): on bit_valid, shift bit_value in MSB-first and bit_cnt++.
//   - When bit_cnt reaches 7->wrap to 0: byte_valid=1 on the next cycle; byte_cnt increments, saturating at 3.
//   - EN=0: bit_valid ignored, byte_valid never set, bit_cnt/byte_cnt held at 0.
//  Capture: byte_cnt 0/1/2 = G/R/B staged. Completing byte 2 writes COLOR={8'h00,R,G,B} in the same cycle as byte_valid.
//   - Same cycle: NEW<=1, FRAME_CNT++ (16 bit, wraps 0xFFFF->0).
//   - Bytes after the third still pulse byte_valid (demux forwarding) but never touch COLOR.
//  Idle timer: counts while din_sync=0 and clears on din_sync=1.
//   - When the count equals RESET_CYCLES-1: idle=1 for one cycle, then the counter saturates (no re-pulse until din high).
//   - Idle runs even with EN=0, so the demux stays in sync.
//  On idle: bit_cnt, byte_cnt and shift reg cleared.
//   - If bit_cnt!=0, or 0<byte_cnt<3: PARTIAL<=1 and the partial data is dropped.
//  Simultaneous bit_valid and idle: idle clears first, then the bit is taken as bit 0 of the new frame.
//  Registers:
//   0 COLOR      RO  {8'h0,R[7:0],G[7:0],B[7:0]}
//   1 STATUS     [0] NEW W1C, [1] PARTIAL W1C, [2] IN_FRAME RO (byte_cnt!=0 || bit_cnt!=0)
//   2 CTRL       RW  [0] EN, [1] IRQ_EN, other bits read 0
//   3 FRAME_CNT  RO [15:0]; any write clears it to 0
//  Register conflict rules:
//   - A W1C on the same cycle as a hardware set: the set wins.
//   - A FRAME_CNT clear on the same cycle as an increment: the result is 0.
//   - Clearing EN mid-byte zeroes bit_cnt/byte_cnt next cycle; COLOR/NEW are kept.
//  Read: rdata is captured from addr on rd_en; rd_ready and rdata are valid the next cycle, otherwise rdata=0.
//   - Read-then-write to the same register in one cycle returns the pre-write value.
//  Reset mid-frame: everything returns to reset values next cycle, no idle or byte_valid pulse emitted.
// STRUCTURE
//  ws2812b_pkg: register address localparams, STATUS/CTRL bit indices, GRB byte indices, default RESET_CYCLES.
//  Sub-module ws2812b_idle_timer (din_sync, counter, saturating compare, idle pulse); the rest stays inline.
// TESTING
//  1. EN=1, send bits 0xFF,0x10,0x01 then 50 us low -> COLOR=0x0010FF01, NEW=1, irq only if IRQ_EN=1, FRAME_CNT=1, idle pulses once.
//  2. 6 bytes then idle -> 6 byte_valid pulses, COLOR = first triplet only, FRAME_CNT=1.
//  3. 13 bits then idle -> PARTIAL=1, NEW=0, COLOR unchanged; write STATUS=0x2 -> PARTIAL=0.
//  4. W1C of NEW on the same cycle as the 3rd byte completing -> NEW stays 1; FRAME_CNT write during an increment -> 0.
//  5. EN=0 with traffic -> no byte_valid, COLOR unchanged, idle still pulses after RESET_CYCLES low.
//  6. Reset asserted after 10 bits -> all outputs 0 next cycle; a following clean frame captures correctly.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared constants for the WS2812B capture path: register map, STATUS/CTRL bit
// positions, GRB byte sequencing and default frame-end timing.
package ws2812b_pkg;

    localparam logic [1:0] ADDR_COLOR     = 2'd0;
    localparam logic [1:0] ADDR_STATUS    = 2'd1;
    localparam logic [1:0] ADDR_CTRL      = 2'd2;
    localparam logic [1:0] ADDR_FRAME_CNT = 2'd3;

    localparam int ST_NEW      = 0;
    localparam int ST_PARTIAL  = 1;
    localparam int ST_IN_FRAME = 2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int DEFAULT_RESET_CYCLES = 3200;
    localparam int DEFAULT_CNT_W        = 12;

    // Position of the byte being assembled within a frame; EXTRA covers every
    // byte after the first GRB triplet.
    typedef enum logic [1:0] {
        BYTE_G     = 2'd0,
        BYTE_R     = 2'd1,
        BYTE_B     = 2'd2,
        BYTE_EXTRA = 2'd3
    } byte_idx_e;

    function automatic logic [31:0] pack_color(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/ws2812b_capture_ctrl_if.sv
// tinyQV peripheral bus view of the capture controller, including its level irq.
interface ws2812b_capture_ctrl_if;
    logic [1:0]  addr;
    logic        wr_en;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rd_ready;
    logic        irq;

    modport master (output addr, wr_en, wdata, rd_en, input rdata, rd_ready, irq);
    modport slave  (input addr, wr_en, wdata, rd_en, output rdata, rd_ready, irq);
endinterface

// File: rtl/ws2812b_idle_timer.sv
// Frame-end detector: counts consecutive din-low cycles and emits one idle pulse
// per low period once RESET_CYCLES have elapsed.
module ws2812b_idle_timer
    import ws2812b_pkg::*;
#(
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic din_sync,
    output logic idle
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RESET_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic             idle_r;

    // Low-time counter saturating one past the compare so the pulse cannot repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            idle_r <= 1'b0;
        end else if (din_sync) begin
            cnt_r  <= '0;
            idle_r <= 1'b0;
        end else begin
            idle_r <= (cnt_r == CNT_LAST);
            if (cnt_r != CNT_SAT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign idle = idle_r;
endmodule

// File: rtl/ws2812b_capture_ctrl.sv
// Byte assembly, first-GRB capture and register file for the WS2812B input path.
module ws2812b_capture_ctrl
    import ws2812b_pkg::*;
#(
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din_sync,
    input  logic                         bit_valid,
    input  logic                         bit_value,
    output logic                         byte_valid,
    output logic                         idle,
    ws2812b_capture_ctrl_if.slave        bus
);
    logic        idle_s;
    logic [2:0]  bit_cnt_r,  bit_cnt_nx,  base_bit_s;
    byte_idx_e   byte_cnt_r, byte_cnt_nx, base_byte_s;
    logic [7:0]  shift_r,    shift_nx,    base_shift_s;
    logic [7:0]  g_r, g_nx, r_r, r_nx;
    logic [31:0] color_r, color_nx;
    logic        new_r, new_nx, partial_r, partial_nx;
    logic [1:0]  ctrl_r, ctrl_nx;
    logic [15:0] frame_cnt_r, frame_cnt_nx;
    logic        byte_valid_r, byte_valid_nx;
    logic [31:0] rdata_r, rdata_nx;
    logic        rd_ready_r, irq_r, irq_nx;
    logic        frame_set_s, partial_set_s, wr_status_s, in_frame_s;
    logic        unused_wdata_s;

    ws2812b_idle_timer #(.RESET_CYCLES(RESET_CYCLES), .CNT_W(CNT_W)) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .din_sync (din_sync),
        .idle     (idle_s)
    );

    assign unused_wdata_s = ^bus.wdata[31:2];
    assign in_frame_s     = (byte_cnt_r != BYTE_G) || (bit_cnt_r != 3'd0);
    assign wr_status_s    = bus.wr_en && (bus.addr == ADDR_STATUS);

    // Next-state for assembly, capture and registers; idle resets the frame
    // before a coincident bit is accepted, so that bit starts the new frame.
    always_comb begin
        base_bit_s    = idle_s ? 3'd0   : bit_cnt_r;
        base_byte_s   = idle_s ? BYTE_G : byte_cnt_r;
        base_shift_s  = idle_s ? 8'h00  : shift_r;
        partial_set_s = idle_s && ((bit_cnt_r != 3'd0) ||
                                   (byte_cnt_r == BYTE_R) || (byte_cnt_r == BYTE_B));
        bit_cnt_nx    = base_bit_s;
        byte_cnt_nx   = base_byte_s;
        shift_nx      = base_shift_s;
        g_nx          = g_r;
        r_nx          = r_r;
        color_nx      = color_r;
        byte_valid_nx = 1'b0;
        frame_set_s   = 1'b0;

        if (!ctrl_r[CTRL_EN]) begin
            bit_cnt_nx  = 3'd0;
            byte_cnt_nx = BYTE_G;
            shift_nx    = 8'h00;
        end else if (bit_valid) begin
            shift_nx = {base_shift_s[6:0], bit_value};
            if (base_bit_s == 3'd7) begin
                bit_cnt_nx    = 3'd0;
                byte_valid_nx = 1'b1;
                byte_cnt_nx   = (base_byte_s == BYTE_EXTRA) ? BYTE_EXTRA
                                                            : byte_idx_e'(base_byte_s + 2'd1);
                case (base_byte_s)
                    BYTE_G:  g_nx = shift_nx;
                    BYTE_R:  r_nx = shift_nx;
                    BYTE_B: begin
                        color_nx    = pack_color(r_r, g_r, shift_nx);
                        frame_set_s = 1'b1;
                    end
                    default: color_nx = color_r;
                endcase
            end else begin
                bit_cnt_nx = base_bit_s + 3'd1;
            end
        end else begin
            shift_nx = base_shift_s;
        end

        // Hardware sets take priority over software W1C.
        if (frame_set_s) begin
            new_nx = 1'b1;
        end else if (wr_status_s && bus.wdata[ST_NEW]) begin
            new_nx = 1'b0;
        end else begin
            new_nx = new_r;
        end

        if (partial_set_s) begin
            partial_nx = 1'b1;
        end else if (wr_status_s && bus.wdata[ST_PARTIAL]) begin
            partial_nx = 1'b0;
        end else begin
            partial_nx = partial_r;
        end

        if (bus.wr_en && (bus.addr == ADDR_CTRL)) begin
            ctrl_nx = bus.wdata[1:0];
        end else begin
            ctrl_nx = ctrl_r;
        end

        if (bus.wr_en && (bus.addr == ADDR_FRAME_CNT)) begin
            frame_cnt_nx = 16'h0000;
        end else if (frame_set_s) begin
            frame_cnt_nx = frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_nx = frame_cnt_r;
        end

        irq_nx = new_nx && ctrl_nx[CTRL_IRQ_EN];

        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_COLOR:     rdata_nx = color_r;
                ADDR_STATUS:    rdata_nx = {29'd0, in_frame_s, partial_r, new_r};
                ADDR_CTRL:      rdata_nx = {30'd0, ctrl_r};
                ADDR_FRAME_CNT: rdata_nx = {16'd0, frame_cnt_r};
                default:        rdata_nx = 32'h0000_0000;
            endcase
        end else begin
            rdata_nx = 32'h0000_0000;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= BYTE_G;
            shift_r      <= 8'h00;
            g_r          <= 8'h00;
            r_r          <= 8'h00;
            color_r      <= 32'h0000_0000;
            new_r        <= 1'b0;
            partial_r    <= 1'b0;
            ctrl_r       <= 2'b00;
            frame_cnt_r  <= 16'h0000;
            byte_valid_r <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            rd_ready_r   <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            bit_cnt_r    <= bit_cnt_nx;
            byte_cnt_r   <= byte_cnt_nx;
            shift_r      <= shift_nx;
            g_r          <= g_nx;
            r_r          <= r_nx;
            color_r      <= color_nx;
            new_r        <= new_nx;
            partial_r    <= partial_nx;
            ctrl_r       <= ctrl_nx;
            frame_cnt_r  <= frame_cnt_nx;
            byte_valid_r <= byte_valid_nx;
            rdata_r      <= rdata_nx;
            rd_ready_r   <= bus.rd_en;
            irq_r        <= irq_nx;
        end
    end

    assign byte_valid   = byte_valid_r;
    assign idle         = idle_s;
    assign bus.rdata    = rdata_r;
    assign bus.rd_ready = rd_ready_r;
    assign bus.irq      = irq_r;
endmodule
